// File: rtl/cpu_pkg.sv
// Shared types for the 16-bit CPU control path: opcodes, ALU selects,
// sequencer states and the decoded control bundle.
package cpu_pkg;

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_ADD  = 4'h1,
        OP_SUB  = 4'h2,
        OP_AND  = 4'h3,
        OP_OR   = 4'h4,
        OP_XOR  = 4'h5,
        OP_SHL  = 4'h6,
        OP_SHR  = 4'h7,
        OP_ADDI = 4'h8,
        OP_LD   = 4'h9,
        OP_ST   = 4'hA,
        OP_BEQ  = 4'hB,
        OP_JMP  = 4'hC,
        OP_HALT = 4'hF
    } op_t;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SHL = 3'b101;
    localparam logic [2:0] ALU_SHR = 3'b110;
    localparam logic [2:0] ALU_MEM = 3'b111;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT_MEM,
        S_DECODE,
        S_EXEC,
        S_WAIT_ALU,
        S_WB,
        S_HALT,
        S_FAULT
    } cu_state_t;

    localparam int OP_LSB  = 12;
    localparam int RD_LSB  = 9;
    localparam int RS1_LSB = 6;
    localparam int RS2_LSB = 3;

    typedef struct packed {
        logic [2:0] alu_sel;
        logic [2:0] rf_wr_sel;
        logic [2:0] reg_1_sel;
        logic [2:0] reg_2_sel;
        logic       pc_sel;
        logic       r1_sel;
        logic       r2_sel;
        logic       rf_write_sel;
        logic       write_rf_bool;
    } ctrl_t;

    function automatic logic [2:0] reg_field(logic [15:0] ir, int lsb);
        return ir[lsb +: 3];
    endfunction

endpackage

// File: rtl/cpu_decoder.sv
// Combinational instruction decoder: IR plus the BEQ equality flag
// become the datapath control bundle and instruction class flags.
module cpu_decoder
    import cpu_pkg::*;
(
    input  logic [15:0] ir,
    input  logic        eq,
    output ctrl_t       ctrl,
    output logic        is_nop,
    output logic        is_halt,
    output logic        illegal
);

    op_t op;

    always_comb begin
        op                = op_t'(ir[OP_LSB +: 4]);
        ctrl              = '0;
        ctrl.rf_wr_sel    = reg_field(ir, RD_LSB);
        ctrl.reg_1_sel    = reg_field(ir, RS1_LSB);
        ctrl.reg_2_sel    = reg_field(ir, RS2_LSB);
        is_nop            = 1'b0;
        is_halt           = 1'b0;
        illegal           = 1'b0;
        unique case (op)
            OP_NOP:  is_nop = 1'b1;
            OP_ADD:  begin ctrl.alu_sel = ALU_ADD; ctrl.rf_write_sel = 1'b1; ctrl.write_rf_bool = 1'b1; end
            OP_SUB:  begin ctrl.alu_sel = ALU_SUB; ctrl.rf_write_sel = 1'b1; ctrl.write_rf_bool = 1'b1; end
            OP_AND:  begin ctrl.alu_sel = ALU_AND; ctrl.rf_write_sel = 1'b1; ctrl.write_rf_bool = 1'b1; end
            OP_OR:   begin ctrl.alu_sel = ALU_OR;  ctrl.rf_write_sel = 1'b1; ctrl.write_rf_bool = 1'b1; end
            OP_XOR:  begin ctrl.alu_sel = ALU_XOR; ctrl.rf_write_sel = 1'b1; ctrl.write_rf_bool = 1'b1; end
            OP_SHL:  begin ctrl.alu_sel = ALU_SHL; ctrl.rf_write_sel = 1'b1; ctrl.write_rf_bool = 1'b1; end
            OP_SHR:  begin ctrl.alu_sel = ALU_SHR; ctrl.rf_write_sel = 1'b1; ctrl.write_rf_bool = 1'b1; end
            OP_ADDI: begin
                ctrl.alu_sel       = ALU_ADD;
                ctrl.r2_sel        = 1'b1;
                ctrl.rf_write_sel  = 1'b1;
                ctrl.write_rf_bool = 1'b1;
            end
            OP_LD:   begin ctrl.alu_sel = ALU_MEM; ctrl.r2_sel = 1'b1; ctrl.write_rf_bool = 1'b1; end
            OP_ST:   begin ctrl.alu_sel = ALU_MEM; ctrl.r2_sel = 1'b1; end
            OP_BEQ:  begin
                ctrl.alu_sel = ALU_ADD;
                ctrl.r1_sel  = 1'b1;
                ctrl.r2_sel  = 1'b1;
                ctrl.pc_sel  = eq;
            end
            OP_JMP:  begin
                ctrl.alu_sel = ALU_ADD;
                ctrl.r1_sel  = 1'b1;
                ctrl.r2_sel  = 1'b1;
                ctrl.pc_sel  = 1'b1;
            end
            OP_HALT: is_halt = 1'b1;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/cpu_control_unit.sv
// Multi-cycle sequencer: fetch over the request/ready port, decode,
// start the datapath and wait for its completion, then update the PC.
module cpu_control_unit
    import cpu_pkg::*;
#(
    parameter int          ALU_TIMEOUT = 64,
    parameter logic [15:0] RESET_PC    = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_rdata,
    input  logic        imem_ready,
    output logic [15:0] ir,
    output logic [15:0] pc,
    input  logic [15:0] dp_pc_out,
    input  logic        dp_done,
    input  logic [15:0] reg_1_val,
    input  logic [15:0] reg_2_val,
    output logic [2:0]  rf_wr_sel,
    output logic [2:0]  reg_1_sel,
    output logic [2:0]  reg_2_sel,
    output logic [2:0]  ALU_sel,
    output logic        PC_sel,
    output logic        R1_sel,
    output logic        R2_sel,
    output logic        rf_write_sel,
    output logic        write_rf_bool,
    output logic        begin_instruction,
    output logic        halted,
    output logic        fault
);

    localparam int               CNT_W   = $clog2(ALU_TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(ALU_TIMEOUT - 1);

    cu_state_t        state_q, state_d;
    logic [15:0]      pc_q, pc_d;
    logic [15:0]      ir_q, ir_d;
    ctrl_t            ctrl_q, ctrl_d;
    logic             halted_q, halted_d;
    logic             fault_q, fault_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    ctrl_t dec_ctrl;
    logic  dec_nop;
    logic  dec_halt;
    logic  dec_illegal;

    cpu_decoder u_dec (
        .ir      (ir_q),
        .eq      (reg_1_val == reg_2_val),
        .ctrl    (dec_ctrl),
        .is_nop  (dec_nop),
        .is_halt (dec_halt),
        .illegal (dec_illegal)
    );

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        ctrl_d   = ctrl_q;
        halted_d = halted_q;
        fault_d  = fault_q;
        cnt_d    = cnt_q;
        unique case (state_q)
            S_IDLE:     if (run) state_d = S_FETCH;
            S_FETCH:    state_d = S_WAIT_MEM;
            S_WAIT_MEM: begin
                if (imem_ready) begin
                    ir_d    = imem_rdata;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                ctrl_d = dec_ctrl;
                if (dec_nop) begin
                    pc_d    = pc_q + 16'd1;
                    state_d = S_FETCH;
                end else if (dec_halt) begin
                    halted_d = 1'b1;
                    state_d  = S_HALT;
                end else if (dec_illegal) begin
                    fault_d = 1'b1;
                    state_d = S_FAULT;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                cnt_d   = '0;
                state_d = S_WAIT_ALU;
            end
            S_WAIT_ALU: begin
                // completion takes priority over a timeout in the same cycle
                if (dp_done) begin
                    state_d = S_WB;
                end else if (cnt_q == CNT_MAX) begin
                    fault_d = 1'b1;
                    state_d = S_FAULT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WB: begin
                pc_d                 = dp_pc_out;
                ctrl_d.write_rf_bool = 1'b0;
                state_d              = run ? S_FETCH : S_IDLE;
            end
            S_HALT:  state_d = S_HALT;
            S_FAULT: state_d = S_FAULT;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            pc_q     <= RESET_PC;
            ir_q     <= '0;
            ctrl_q   <= '0;
            halted_q <= 1'b0;
            fault_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            ctrl_q   <= ctrl_d;
            halted_q <= halted_d;
            fault_q  <= fault_d;
            cnt_q    <= cnt_d;
        end
    end

    // gated by reset so the request drops in the very cycle reset is seen
    assign imem_req = ~reset &
                      ((state_q == S_FETCH) | (state_q == S_WAIT_MEM));

    assign imem_addr         = pc_q;
    assign pc                = pc_q;
    assign ir                = ir_q;
    assign begin_instruction = (state_q == S_EXEC);
    assign halted            = halted_q;
    assign fault             = fault_q;
    assign rf_wr_sel         = ctrl_q.rf_wr_sel;
    assign reg_1_sel         = ctrl_q.reg_1_sel;
    assign reg_2_sel         = ctrl_q.reg_2_sel;
    assign ALU_sel           = ctrl_q.alu_sel;
    assign PC_sel            = ctrl_q.pc_sel;
    assign R1_sel            = ctrl_q.r1_sel;
    assign R2_sel            = ctrl_q.r2_sel;
    assign rf_write_sel      = ctrl_q.rf_write_sel;
    assign write_rf_bool     = ctrl_q.write_rf_bool;

endmodule
